// File: rtl/regfile_seq_pkg.sv
// Shared types for the register-file control sequencer: opcodes, states,
// ALU/bus selectors, instruction field positions and the control word.
package regfile_seq_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned OP_MSB = 9;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RX_MSB = 5;
  localparam int unsigned RX_LSB = 4;
  localparam int unsigned RY_MSB = 3;
  localparam int unsigned RY_LSB = 2;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_MOV  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITIMM,
    S_T1,
    S_T2,
    S_T3,
    S_FIN
  } state_t;

  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_SUB = 3'b001,
    FN_AND = 3'b010,
    FN_OR  = 3'b011,
    FN_XOR = 3'b100,
    FN_NOT = 3'b101
  } alu_fn_t;

  typedef enum logic [1:0] {
    BUS_ZERO = 2'b00,
    BUS_DIN  = 2'b01,
    BUS_Q0   = 2'b10,
    BUS_G    = 2'b11
  } bus_sel_t;

  typedef struct packed {
    logic              enw;
    logic [ADDR_W-1:0] wra;
    logic              enr0;
    logic [ADDR_W-1:0] rda0;
    logic              enr1;
    logic [ADDR_W-1:0] rda1;
    logic              lda;
    logic              ldg;
    alu_fn_t           alu_fn;
    bus_sel_t          bus_sel;
    logic              busy;
    logic              done;
  } ctrl_t;

  function automatic alu_fn_t alu_fn_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return FN_SUB;
      OP_AND:  return FN_AND;
      OP_OR:   return FN_OR;
      OP_XOR:  return FN_XOR;
      OP_NOT:  return FN_NOT;
      default: return FN_ADD;
    endcase
  endfunction

endpackage

// File: rtl/regfile_sequencer_seq_decode.sv
// Combinational decode: (state, IR, strobe) -> next state, next IR and the
// control word that will be registered for the next state.
module seq_decode
  import regfile_seq_pkg::*;
(
  input  state_t            state,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] din,
  input  logic              pext,
  output state_t            state_nxt,
  output logic [DATA_W-1:0] ir_nxt,
  output ctrl_t             ctrl_nxt
);

  logic [3:0]        op;
  logic [ADDR_W-1:0] rx;
  logic [ADDR_W-1:0] ry;

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    case (state)
      S_IDLE: begin
        if (pext) begin
          ir_nxt = din;
          if (din[OP_MSB:OP_LSB] == OP_LOAD) state_nxt = S_WAITIMM;
          else if (din[OP_MSB])              state_nxt = S_FIN;
          else                               state_nxt = S_T1;
        end
      end
      S_WAITIMM: if (pext) state_nxt = S_T1;
      S_T1: begin
        case (ir[OP_MSB:OP_LSB])
          OP_LOAD, OP_MOV: state_nxt = S_FIN;
          OP_NOT:          state_nxt = S_T3;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_nxt = S_T2;
          default:         state_nxt = S_FIN;
        endcase
      end
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoded from the IR value that will be held in the next state, so the
  // first control word of an instruction is ready on the sampling edge.
  assign op = ir_nxt[OP_MSB:OP_LSB];
  assign rx = ir_nxt[RX_MSB:RX_LSB];
  assign ry = ir_nxt[RY_MSB:RY_LSB];

  always_comb begin
    ctrl_nxt      = '0;
    ctrl_nxt.busy = (state_nxt != S_IDLE);
    case (state_nxt)
      S_T1: begin
        case (op)
          OP_LOAD: begin
            ctrl_nxt.bus_sel = BUS_DIN;
            ctrl_nxt.enw     = 1'b1;
            ctrl_nxt.wra     = rx;
          end
          OP_MOV: begin
            ctrl_nxt.enr0    = 1'b1;
            ctrl_nxt.rda0    = ry;
            ctrl_nxt.bus_sel = BUS_Q0;
            ctrl_nxt.enw     = 1'b1;
            ctrl_nxt.wra     = rx;
          end
          OP_NOT: begin
            ctrl_nxt.enr1   = 1'b1;
            ctrl_nxt.rda1   = ry;
            ctrl_nxt.alu_fn = FN_NOT;
            ctrl_nxt.ldg    = 1'b1;
          end
          default: begin
            ctrl_nxt.enr0 = 1'b1;
            ctrl_nxt.rda0 = rx;
            ctrl_nxt.lda  = 1'b1;
          end
        endcase
      end
      S_T2: begin
        ctrl_nxt.enr1   = 1'b1;
        ctrl_nxt.rda1   = ry;
        ctrl_nxt.alu_fn = alu_fn_of(op);
        ctrl_nxt.ldg    = 1'b1;
      end
      S_T3: begin
        ctrl_nxt.bus_sel = BUS_G;
        ctrl_nxt.enw     = 1'b1;
        ctrl_nxt.wra     = rx;
      end
      S_FIN:   ctrl_nxt.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle control sequencer for the 4x10-bit register file, ALU and bus
// mux. Holds state, IR and the registered control word.
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic        CLKb,
  input  logic        RSTb,
  input  logic [9:0]  Din,
  input  logic        PEXT,
  output logic [9:0]  IR,
  output logic        ENW,
  output logic [1:0]  WRA,
  output logic        ENR0,
  output logic        ENR1,
  output logic [1:0]  RDA0,
  output logic [1:0]  RDA1,
  output logic        LDA,
  output logic        LDG,
  output logic [2:0]  ALU_FN,
  output logic [1:0]  BUS_SEL,
  output logic        BUSY,
  output logic        DONE
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] ir_nxt;
  ctrl_t             ctrl;
  ctrl_t             ctrl_nxt;

  seq_decode u_decode (
    .state     (state),
    .ir        (IR),
    .din       (Din),
    .pext      (PEXT),
    .state_nxt (state_nxt),
    .ir_nxt    (ir_nxt),
    .ctrl_nxt  (ctrl_nxt)
  );

  // Clearing ctrl asynchronously drops ENW before a pending falling-edge write.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state <= S_IDLE;
      IR    <= '0;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      IR    <= ir_nxt;
      ctrl  <= ctrl_nxt;
    end
  end

  assign ENW     = ctrl.enw;
  assign WRA     = ctrl.wra;
  assign ENR0    = ctrl.enr0;
  assign RDA0    = ctrl.rda0;
  assign ENR1    = ctrl.enr1;
  assign RDA1    = ctrl.rda1;
  assign LDA     = ctrl.lda;
  assign LDG     = ctrl.ldg;
  assign ALU_FN  = ctrl.alu_fn;
  assign BUS_SEL = ctrl.bus_sel;
  assign BUSY    = ctrl.busy;
  assign DONE    = ctrl.done;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: checks the full control word cycle by
// cycle against hand-derived values for each opcode class, reset and PEXT handling.
module tb_regfile_sequencer;

  logic       CLKb = 1'b0;
  logic       RSTb = 1'b0;
  logic [9:0] Din  = '0;
  logic       PEXT = 1'b0;
  logic [9:0] IR;
  logic       ENW, ENR0, ENR1, LDA, LDG, BUSY, DONE;
  logic [1:0] WRA, RDA0, RDA1, BUS_SEL;
  logic [2:0] ALU_FN;

  int n_vec = 0;
  int n_err = 0;
  int enw_cnt = 0;
  int done_cnt = 0;
  int snap_enw;
  int snap_done;

  regfile_sequencer dut (
    .CLKb(CLKb), .RSTb(RSTb), .Din(Din), .PEXT(PEXT), .IR(IR),
    .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .ENR1(ENR1), .RDA0(RDA0), .RDA1(RDA1),
    .LDA(LDA), .LDG(LDG), .ALU_FN(ALU_FN), .BUS_SEL(BUS_SEL),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLKb = ~CLKb;

  // The register file writes on the falling edge; count writes and completions there.
  always @(negedge CLKb) begin
    if (ENW)  enw_cnt++;
    if (DONE) done_cnt++;
  end

  function automatic logic [17:0] cw(input logic enw, input logic [1:0] wra,
                                     input logic enr0, input logic [1:0] rda0,
                                     input logic enr1, input logic [1:0] rda1,
                                     input logic lda, input logic ldg,
                                     input logic [2:0] fn, input logic [1:0] bs,
                                     input logic busy, input logic done);
    return {enw, wra, enr0, rda0, enr1, rda1, lda, ldg, fn, bs, busy, done};
  endfunction

  function automatic logic [17:0] obs_cw();
    return {ENW, WRA, ENR0, RDA0, ENR1, RDA1, LDA, LDG, ALU_FN, BUS_SEL, BUSY, DONE};
  endfunction

  task automatic chk_cw(input string tag, input logic [17:0] expv);
    logic [17:0] o;
    o = obs_cw();
    n_vec++;
    assert (o === expv) else begin
      n_err++;
      $error("FAIL %s: observed ctrl %b, expected %b", tag, o, expv);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] expv);
    n_vec++;
    assert (o === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, o, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLKb);
    #1;
  endtask

  localparam logic [17:0] CW_IDLE = 18'd0;
  localparam logic [17:0] CW_BUSY = 18'b000000000000000010;
  localparam logic [17:0] CW_FIN  = 18'b000000000000000011;

  initial begin
    // Reset state
    #2;
    chk_cw("reset_ctrl", CW_IDLE);
    chk("reset_ir", {22'd0, IR}, 32'h0);
    #20;
    RSTb = 1'b1;
    tick();
    chk_cw("idle_after_reset", CW_IDLE);

    // LOAD R2, immediate 0x155 after one wait cycle
    Din = 10'h020; PEXT = 1'b1;
    tick();
    chk_cw("load_waitimm", CW_BUSY);
    chk("load_ir", {22'd0, IR}, 32'h020);
    Din = 10'h3FF; PEXT = 1'b0;
    tick();
    chk_cw("load_still_wait", CW_BUSY);
    Din = 10'h155; PEXT = 1'b1;
    tick();
    chk_cw("load_t1", cw(1, 2'd2, 0, 0, 0, 0, 0, 0, 3'b000, 2'b01, 1, 0));
    PEXT = 1'b0;
    tick();
    chk_cw("load_fin", CW_FIN);
    chk("load_ir_kept", {22'd0, IR}, 32'h020);
    tick();
    chk_cw("load_idle", CW_IDLE);

    // MOV R3,R2
    Din = 10'h078; PEXT = 1'b1;
    tick();
    PEXT = 1'b0;
    chk_cw("mov_t1", cw(1, 2'd3, 1, 2'd2, 0, 0, 0, 0, 3'b000, 2'b10, 1, 0));
    tick();
    chk_cw("mov_fin", CW_FIN);
    tick();
    chk_cw("mov_idle", CW_IDLE);

    // SUB R1,R0
    Din = 10'h0D0; PEXT = 1'b1;
    tick();
    PEXT = 1'b0;
    chk_cw("sub_t1", cw(0, 0, 1, 2'd1, 0, 0, 1, 0, 3'b000, 2'b00, 1, 0));
    tick();
    chk_cw("sub_t2", cw(0, 0, 0, 0, 1, 2'd0, 0, 1, 3'b001, 2'b00, 1, 0));
    tick();
    chk_cw("sub_t3", cw(1, 2'd1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b11, 1, 0));
    tick();
    chk_cw("sub_fin", CW_FIN);
    tick();
    chk_cw("sub_idle", CW_IDLE);

    // AND R2,R1 with PEXT pulses while busy, then NOP 1010
    Din = 10'h124; PEXT = 1'b1;
    tick();
    Din = 10'h3FF;
    chk_cw("and_t1", cw(0, 0, 1, 2'd2, 0, 0, 1, 0, 3'b000, 2'b00, 1, 0));
    tick();
    chk_cw("and_t2", cw(0, 0, 0, 0, 1, 2'd1, 0, 1, 3'b010, 2'b00, 1, 0));
    chk("and_ir_held", {22'd0, IR}, 32'h124);
    PEXT = 1'b0;
    tick();
    chk_cw("and_t3", cw(1, 2'd2, 0, 0, 0, 0, 0, 0, 3'b000, 2'b11, 1, 0));
    PEXT = 1'b1;
    tick();
    chk_cw("and_fin", CW_FIN);
    chk("and_ir_end", {22'd0, IR}, 32'h124);
    PEXT = 1'b0;
    tick();
    chk_cw("and_idle", CW_IDLE);
    snap_enw = enw_cnt;
    Din = 10'h280; PEXT = 1'b1;
    tick();
    PEXT = 1'b0;
    chk_cw("nop_fin", CW_FIN);
    chk("nop_ir", {22'd0, IR}, 32'h280);
    tick();
    chk_cw("nop_idle", CW_IDLE);
    chk("nop_no_write", enw_cnt, snap_enw);

    // ADD R0,R1 aborted by reset in T2
    Din = 10'h084; PEXT = 1'b1;
    tick();
    PEXT = 1'b0;
    tick();
    chk_cw("add_t2", cw(0, 0, 0, 0, 1, 2'd1, 0, 1, 3'b000, 2'b00, 1, 0));
    #2;
    RSTb = 1'b0;
    #1;
    chk_cw("rst_async_ctrl", CW_IDLE);
    chk("rst_async_ir", {22'd0, IR}, 32'h0);
    snap_enw = enw_cnt;
    @(negedge CLKb);
    #1;
    chk("rst_no_write", enw_cnt, snap_enw);
    RSTb = 1'b1;
    tick();
    chk_cw("rst_idle", CW_IDLE);
    tick();
    chk("rst_no_write_after", enw_cnt, snap_enw);

    // Back-to-back with PEXT held: NOT R0,R3 then XOR R2,R2
    snap_enw  = enw_cnt;
    snap_done = done_cnt;
    Din = 10'h1CC; PEXT = 1'b1;
    tick();
    Din = 10'h1A8;
    chk_cw("not_t1", cw(0, 0, 0, 0, 1, 2'd3, 0, 1, 3'b101, 2'b00, 1, 0));
    chk("not_ir", {22'd0, IR}, 32'h1CC);
    tick();
    chk_cw("not_t3", cw(1, 2'd0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b11, 1, 0));
    tick();
    chk_cw("not_fin", CW_FIN);
    chk("not_ir_fin", {22'd0, IR}, 32'h1CC);
    tick();
    chk_cw("b2b_gap_idle", CW_IDLE);
    chk("b2b_ir_gap", {22'd0, IR}, 32'h1CC);
    tick();
    chk_cw("xor_t1", cw(0, 0, 1, 2'd2, 0, 0, 1, 0, 3'b000, 2'b00, 1, 0));
    chk("xor_ir", {22'd0, IR}, 32'h1A8);
    tick();
    chk_cw("xor_t2", cw(0, 0, 0, 0, 1, 2'd2, 0, 1, 3'b100, 2'b00, 1, 0));
    tick();
    chk_cw("xor_t3", cw(1, 2'd2, 0, 0, 0, 0, 0, 0, 3'b000, 2'b11, 1, 0));
    tick();
    chk_cw("xor_fin", CW_FIN);
    PEXT = 1'b0;
    tick();
    chk_cw("b2b_idle", CW_IDLE);
    chk("b2b_done_pulses", done_cnt - snap_done, 32'd2);
    chk("b2b_writes", enw_cnt - snap_enw, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
